// File: rtl/led_sequencer_if.sv
// Signal bundle between the board controls (switches/buttons) and led_sequencer.
// The master drives the controls; the slave (the sequencer) drives the LEDs and the step pulse.
interface led_sequencer_if #(
  parameter int unsigned LED_NUM  = 4,
  parameter int unsigned PWM_BITS = 4
);
  logic [1:0]          sw;
  logic [1:0]          speed;
  logic                pause;
  logic [PWM_BITS-1:0] duty;
  logic [LED_NUM-1:0]  led;
  logic                step_o;

  modport master (output sw, speed, pause, duty, input led, step_o);
  modport slave  (input sw, speed, pause, duty, output led, step_o);
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate-left, rotate-right, bounce and blink-all, with speed select and pause.
// Optional brightness PWM on the LED outputs is compiled in with `define LED_SEQ_PWM_EN.
module led_sequencer #(
  parameter int unsigned LED_NUM  = 4,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic           clk_i,
  input  logic           rst_n,
  led_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [LED_NUM-1:0] pattern_q, pattern_d;
  logic [1:0]         sw_q, sw_d;
  logic               dir_up_q, dir_up_d;
  logic               step_q, step_d;
  logic               tick;
  logic [31:0]        period_m1;
  logic [LED_NUM-1:0] start_val, next_val;
  logic               next_dir_up;

  assign period_m1 = (32'(TICK_DIV) >> bus.speed) - 32'd1;

  always_comb begin
    start_val = '0;
    case (bus.sw)
      2'd0, 2'd2: start_val[0] = 1'b1;
      2'd1:       start_val[LED_NUM-1] = 1'b1;
      default:    start_val = '1;
    endcase
  end

  // Bounce turns around when the lit bit reaches an end, so each endpoint is shown once per pass.
  always_comb begin
    next_val    = pattern_q;
    next_dir_up = dir_up_q;
    case (sw_q)
      2'd0: next_val = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
      2'd1: next_val = {pattern_q[0], pattern_q[LED_NUM-1:1]};
      2'd2: begin
        if (dir_up_q && pattern_q[LED_NUM-1]) begin
          next_val    = pattern_q >> 1;
          next_dir_up = 1'b0;
        end else if (!dir_up_q && pattern_q[0]) begin
          next_val    = pattern_q << 1;
          next_dir_up = 1'b1;
        end else if (dir_up_q) begin
          next_val = pattern_q << 1;
        end else begin
          next_val = pattern_q >> 1;
        end
      end
      default: next_val = ~pattern_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    pattern_d = pattern_q;
    sw_d      = sw_q;
    dir_up_d  = dir_up_q;
    tick      = 1'b0;
    if (state_q == S_LOAD || bus.sw != sw_q) begin
      pattern_d = start_val;
      div_cnt_d = '0;
      sw_d      = bus.sw;
      dir_up_d  = 1'b1;
      state_d   = (state_q != S_LOAD && bus.pause) ? S_HOLD : S_RUN;
    end else begin
      state_d = bus.pause ? S_HOLD : S_RUN;
      // A sampled pause freezes the count on that very edge, so the remaining count survives a hold.
      if (!bus.pause) begin
        if (32'(div_cnt_q) >= period_m1) begin
          tick      = 1'b1;
          div_cnt_d = '0;
          pattern_d = next_val;
          dir_up_d  = next_dir_up;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
    end
    step_d = tick;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      div_cnt_q <= '0;
      pattern_q <= '0;
      sw_q      <= 2'd0;
      dir_up_q  <= 1'b1;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      pattern_q <= pattern_d;
      sw_q      <= sw_d;
      dir_up_q  <= dir_up_d;
      step_q    <= step_d;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_on_q, pwm_on_d;
  logic [LED_NUM-1:0]  led_q, led_d;
  logic                step_dly_q, step_dly_d;

  // The extra led register costs one cycle, so step is delayed by the same amount.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    pwm_on_d   = (pwm_cnt_q < bus.duty);
    led_d      = pattern_q & {LED_NUM{pwm_on_q}};
    step_dly_d = step_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q  <= '0;
      pwm_on_q   <= 1'b0;
      led_q      <= '0;
      step_dly_q <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_on_q   <= pwm_on_d;
      led_q      <= led_d;
      step_dly_q <= step_dly_d;
    end
  end

  assign bus.led    = led_q;
  assign bus.step_o = step_dly_q;
`else
  assign bus.led    = pattern_q;
  assign bus.step_o = step_q;
`endif
endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (default build, LED_NUM=4, TICK_DIV=16).
// Expected LEDs come from a step-count model: pattern = f(mode, steps since load).
module tb_led_sequencer;
  localparam int N   = 4;
  localparam int DIV = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  led_sequencer_if #(.LED_NUM(N), .PWM_BITS(4)) bus ();

  led_sequencer #(.LED_NUM(N), .TICK_DIV(DIV), .PWM_BITS(4)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: loaded flag, current mode, steps since load, counted cycles since last step.
  bit m_loaded = 0;
  int m_mode   = 0;
  int m_k      = 0;
  int m_cnt    = 0;
  bit m_step   = 0;

  function automatic logic [N-1:0] exp_led();
    int pos, idx;
    if (!m_loaded) return '0;
    case (m_mode)
      0: return N'(1 << (m_k % N));
      1: return N'((1 << (N - 1)) >> (m_k % N));
      2: begin
        pos = m_k % (2 * (N - 1));
        idx = (pos < N) ? pos : 2 * (N - 1) - pos;
        return N'(1 << idx);
      end
      default: return (m_k % 2 == 0) ? {N{1'b1}} : '0;
    endcase
  endfunction

  function automatic logic [N-1:0] start_of(input int mode);
    logic [N-1:0] v;
    v = '0;
    case (mode)
      1: v[N-1] = 1'b1;
      3: v = '1;
      default: v[0] = 1'b1;
    endcase
    return v;
  endfunction

  // Advance one clock edge, update the model from the inputs in force at that edge, sample 1 ns later.
  task automatic clk_step();
    int p;
    @(posedge clk);
    if (!rst_n) begin
      m_loaded = 0; m_mode = 0; m_k = 0; m_cnt = 0; m_step = 0;
    end else begin
      m_step = 0;
      if (!m_loaded || int'(bus.sw) != m_mode) begin
        m_loaded = 1; m_mode = int'(bus.sw); m_k = 0; m_cnt = 0;
      end else if (!bus.pause) begin
        p = DIV >> bus.speed;
        if (m_cnt >= p - 1) begin
          m_k++; m_cnt = 0; m_step = 1;
        end else begin
          m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.sw = 2'd0; bus.speed = 2'd2; bus.pause = 1'b0; bus.duty = '0;
    repeat (3) clk_step();
    tests++;
    if (bus.led !== '0 || bus.step_o !== 1'b0) begin
      failed++;
      $display("FAIL reset: led=%b step=%b, expected led=0000 step=0", bus.led, bus.step_o);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_rotate_left();
    int steps = 0;
    rst_n = 1'b1;
    clk_step();
    tests++;
    if (bus.led !== 4'b0001) begin
      failed++;
      $display("FAIL rotate_first: led=%b, expected 0001", bus.led);
    end
    for (int i = 0; i < 20; i++) begin
      clk_step();
      steps += int'(bus.step_o);
      tests++;
      if (bus.led !== exp_led() || bus.step_o !== m_step) begin
        failed++;
        $display("FAIL rotate cyc%0d: led=%b step=%b, expected led=%b step=%b", i, bus.led, bus.step_o, exp_led(), m_step);
      end
    end
    tests++;
    if (steps != 5) begin
      failed++;
      $display("FAIL rotate_steps: got %0d steps, expected 5", steps);
    end
    $display("[TB] test_rotate_left done");
  endtask

  task automatic test_bounce();
    bus.sw = 2'd2;
    for (int i = 0; i < 34; i++) begin
      clk_step();
      tests++;
      if (bus.led !== exp_led() || bus.step_o !== m_step) begin
        failed++;
        $display("FAIL bounce cyc%0d: led=%b step=%b, expected led=%b step=%b", i, bus.led, bus.step_o, exp_led(), m_step);
      end
    end
    $display("[TB] test_bounce done");
  endtask

  task automatic test_pause();
    int budget = 0;
    bus.sw = 2'd0;
    clk_step();
    while (!(exp_led() == 4'b0100 && m_step) && budget < 40) begin
      clk_step();
      budget++;
    end
    tests++;
    if (budget >= 40 || bus.led !== 4'b0100) begin
      failed++;
      $display("FAIL pause_reach: led=%b after %0d cycles, expected 0100", bus.led, budget);
    end
    repeat (2) clk_step();
    bus.pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      tests++;
      if (bus.led !== 4'b0100 || bus.step_o !== 1'b0) begin
        failed++;
        $display("FAIL pause_hold cyc%0d: led=%b step=%b, expected led=0100 step=0", i, bus.led, bus.step_o);
      end
    end
    bus.pause = 1'b0;
    clk_step();
    clk_step();
    tests++;
    if (bus.led !== 4'b1000 || bus.step_o !== 1'b1) begin
      failed++;
      $display("FAIL pause_resume: led=%b step=%b, expected led=1000 step=1", bus.led, bus.step_o);
    end
    $display("[TB] test_pause done");
  endtask

  task automatic test_mode_change();
    int budget = 0;
    while (exp_led() != 4'b0010 && budget < 40) begin
      clk_step();
      budget++;
    end
    clk_step();
    bus.sw = 2'd3;
    clk_step();
    tests++;
    if (bus.led !== 4'b1111 || bus.step_o !== 1'b0) begin
      failed++;
      $display("FAIL mode_change: led=%b step=%b, expected led=1111 step=0", bus.led, bus.step_o);
    end
    for (int i = 0; i < 10; i++) begin
      clk_step();
      tests++;
      if (bus.led !== exp_led() || bus.step_o !== m_step) begin
        failed++;
        $display("FAIL blink cyc%0d: led=%b step=%b, expected led=%b step=%b", i, bus.led, bus.step_o, exp_led(), m_step);
      end
    end
    $display("[TB] test_mode_change done");
  endtask

  task automatic test_speed();
    int steps = 0;
    bus.sw = 2'd1;
    bus.speed = 2'd3;
    clk_step();
    for (int i = 0; i < 10; i++) begin
      clk_step();
      steps += int'(bus.step_o);
      tests++;
      if (bus.led !== exp_led() || bus.step_o !== m_step) begin
        failed++;
        $display("FAIL speed3 cyc%0d: led=%b step=%b, expected led=%b step=%b", i, bus.led, bus.step_o, exp_led(), m_step);
      end
    end
    tests++;
    if (steps != 5) begin
      failed++;
      $display("FAIL speed3_steps: got %0d steps, expected 5", steps);
    end
    bus.speed = 2'd0;
    steps = 0;
    for (int i = 0; i < 40; i++) begin
      clk_step();
      steps += int'(bus.step_o);
      tests++;
      if (bus.led !== exp_led() || bus.step_o !== m_step) begin
        failed++;
        $display("FAIL speed0 cyc%0d: led=%b step=%b, expected led=%b step=%b", i, bus.led, bus.step_o, exp_led(), m_step);
      end
    end
    tests++;
    if (steps < 2 || steps > 3) begin
      failed++;
      $display("FAIL speed0_steps: got %0d steps in 40 cycles, expected 2..3", steps);
    end
    $display("[TB] test_speed done");
  endtask

  task automatic test_async_reset();
    bus.speed = 2'd2;
    repeat (6) clk_step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.led !== '0 || bus.step_o !== 1'b0) begin
      failed++;
      $display("FAIL async_reset: led=%b step=%b, expected led=0000 step=0", bus.led, bus.step_o);
    end
    clk_step();
    bus.sw = 2'd2;
    rst_n = 1'b1;
    clk_step();
    tests++;
    if (bus.led !== start_of(2) || bus.led !== exp_led()) begin
      failed++;
      $display("FAIL reset_release: led=%b, expected %b", bus.led, start_of(2));
    end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) bus.sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.speed = 2'($urandom_range(0, 3));
      bus.pause = ($urandom_range(0, 4) == 0);
      clk_step();
      tests++;
      if (bus.led !== exp_led() || bus.step_o !== m_step) begin
        failed++;
        $display("FAIL random cyc%0d: led=%b step=%b, expected led=%b step=%b (mode %0d)", i, bus.led, bus.step_o, exp_led(), m_step, m_mode);
      end
    end
    bus.pause = 1'b0;
    $display("[TB] test_random done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rotate_left();
    test_bounce();
    test_pause();
    test_mode_change();
    test_speed();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
